// File: rtl/phase_seq_pkg.sv
// Shared definitions for the phase sequencer and the control unit.
// Holds the MIPS opcode/function constants, the instruction-class enumeration,
// the phase index constants P0..P4, and a helper that builds a one-hot phase vector.
package phase_seq_pkg;

  localparam int NPH = 5;
  localparam int P0  = 0;
  localparam int P1  = 1;
  localparam int P2  = 2;
  localparam int P3  = 3;
  localparam int P4  = 4;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;  // bgez / bltz
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_HILO,
    CLS_ILLEGAL
  } iclass_e;

  function automatic logic [NPH-1:0] phase_oh(input int idx);
    logic [NPH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/phase_seq_instr_class.sv
// Combinational instruction classifier.
// Ports: op, irfunc (instruction fields) -> cls (instruction class).
// Anything not recognised is reported as CLS_ILLEGAL.
module instr_class
  import phase_seq_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] irfunc,
  output iclass_e    cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (irfunc)
          FN_JR, FN_JALR:                             cls = CLS_JUMP;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:         cls = CLS_HILO;
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: cls = CLS_ALU;
          default:                                    cls = CLS_ILLEGAL;
        endcase
      end
      // REGIMM is split by the rt field, which is not visible here; every
      // REGIMM form this core supports (bgez/bltz) is a branch.
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:    cls = CLS_BRANCH;
      OP_J, OP_JAL:                                   cls = CLS_JUMP;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:               cls = CLS_ALU;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:            cls = CLS_LOAD;
      OP_SB, OP_SH, OP_SW:                            cls = CLS_STORE;
      default:                                        cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/phase_seq.sv
// Multi-cycle phase sequencer: drives a registered one-hot phase P0..P4 whose path
// depends on the instruction class latched in P1.
// Ports: clk/reset, run, op/irfunc, mem_ready, alu_busy in; p, stall, retire,
// illegal, cycle_count, retired_count out.
module phase_seq
  import phase_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [5:0]  op,
  input  logic [5:0]  irfunc,
  input  logic        mem_ready,
  input  logic        alu_busy,
  output logic [4:0]  p,
  output logic        stall,
  output logic        retire,
  output logic        illegal,
  output logic [31:0] cycle_count,
  output logic [31:0] retired_count
);

  localparam logic [NPH-1:0] PH0 = phase_oh(P0);
  localparam logic [NPH-1:0] PH1 = phase_oh(P1);
  localparam logic [NPH-1:0] PH2 = phase_oh(P2);
  localparam logic [NPH-1:0] PH3 = phase_oh(P3);
  localparam logic [NPH-1:0] PH4 = phase_oh(P4);

  logic [NPH-1:0] p_q, p_d;
  iclass_e        cls_live, cls_q, cls_d;
  logic [31:0]    cycle_count_q, retired_count_q;
  logic           hold, done, ill;

  instr_class u_instr_class (
    .op     (op),
    .irfunc (irfunc),
    .cls    (cls_live)
  );

  always_comb begin
    p_d   = p_q;
    cls_d = cls_q;
    hold  = 1'b0;
    done  = 1'b0;
    ill   = 1'b0;
    case (p_q)
      PH0: begin
        if (run && mem_ready) p_d = PH1;
        else                  hold = 1'b1;
      end
      // P1 steers on the live class; the latched copy takes over from P2.
      PH1: begin
        cls_d = cls_live;
        if (cls_live == CLS_ILLEGAL) begin
          ill = 1'b1;
          p_d = PH0;
        end else begin
          p_d = PH2;
        end
      end
      PH2: begin
        case (cls_q)
          CLS_BRANCH: begin
            p_d  = PH0;
            done = 1'b1;
          end
          CLS_LOAD, CLS_STORE: p_d = PH3;
          CLS_HILO: begin
            if (alu_busy) hold = 1'b1;
            else          p_d  = PH4;
          end
          default: p_d = PH4;
        endcase
      end
      PH3: begin
        if (!mem_ready) begin
          hold = 1'b1;
        end else if (cls_q == CLS_STORE) begin
          p_d  = PH0;
          done = 1'b1;
        end else begin
          p_d = PH4;
        end
      end
      PH4: begin
        p_d  = PH0;
        done = 1'b1;
      end
      // Not reachable from reset; recover to fetch if the register is upset.
      default: p_d = PH0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q             <= PH0;
      cls_q           <= CLS_ALU;
      cycle_count_q   <= '0;
      retired_count_q <= '0;
    end else begin
      p_q           <= p_d;
      cls_q         <= cls_d;
      cycle_count_q <= cycle_count_q + 32'd1;
      if (done) retired_count_q <= retired_count_q + 32'd1;
    end
  end

  // Pulses are masked while reset is high so an abandoned instruction never
  // shows a retire and the reset values appear immediately.
  assign p             = p_q;
  assign stall         = hold & ~reset;
  assign retire        = done & ~reset;
  assign illegal       = ill & ~reset;
  assign cycle_count   = cycle_count_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_phase_seq.sv
module tb_phase_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [5:0]  op;
  logic [5:0]  irfunc;
  logic        mem_ready;
  logic        alu_busy;
  logic [4:0]  p;
  logic        stall;
  logic        retire;
  logic        illegal;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;

  int n_tests = 0;
  int n_fail  = 0;

  phase_seq dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .op            (op),
    .irfunc        (irfunc),
    .mem_ready     (mem_ready),
    .alu_busy      (alu_busy),
    .p             (p),
    .stall         (stall),
    .retire        (retire),
    .illegal       (illegal),
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic [4:0] pe, input logic se, input logic re);
    #1;
    check({tag, ".p"},      32'(p),      32'(pe));
    check({tag, ".stall"},  32'(stall),  32'(se));
    check({tag, ".retire"}, 32'(retire), 32'(re));
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_ready = 1'b1; alu_busy = 1'b0;
    op = 6'h00; irfunc = 6'h00;

    // Reset values (run=0 would otherwise stall)
    #2;
    expect_cyc("rst", 5'b00001, 1'b0, 1'b0);
    check("rst.illegal", 32'(illegal), 32'd0);
    check("rst.cc", cycle_count, 32'd0);
    check("rst.rc", retired_count, 32'd0);
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // run=0 holds P0 with stall
    next_cycle();
    expect_cyc("hold", 5'b00001, 1'b1, 1'b0);
    check("hold.cc", cycle_count, 32'd1);

    // cycle counter wrap
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    #1;
    check("wrap.pre", cycle_count, 32'hFFFF_FFFF);
    release dut.cycle_count_q;
    next_cycle();
    check("wrap.post", cycle_count, 32'd0);
    expect_cyc("hold2", 5'b00001, 1'b1, 1'b0);

    // add: 4 cycles, retire in P4
    run = 1'b1; op = 6'h00; irfunc = 6'h20;
    expect_cyc("add.c1", 5'b00001, 1'b0, 1'b0);
    next_cycle(); expect_cyc("add.c2", 5'b00010, 1'b0, 1'b0);
    check("add.illegal", 32'(illegal), 32'd0);
    next_cycle(); expect_cyc("add.c3", 5'b00100, 1'b0, 1'b0);
    next_cycle(); expect_cyc("add.c4", 5'b10000, 1'b0, 1'b1);
    check("add.rc_pre", retired_count, 32'd0);
    next_cycle();
    check("add.rc", retired_count, 32'd1);

    // lw with 3 wait cycles in P3: 8 cycles total
    op = 6'h23; irfunc = 6'h00;
    expect_cyc("lw.c1", 5'b00001, 1'b0, 1'b0);
    next_cycle(); expect_cyc("lw.c2", 5'b00010, 1'b0, 1'b0);
    next_cycle(); expect_cyc("lw.c3", 5'b00100, 1'b0, 1'b0);
    next_cycle(); mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_cyc("lw.wait", 5'b01000, 1'b1, 1'b0);
      next_cycle();
    end
    mem_ready = 1'b1;
    expect_cyc("lw.c7", 5'b01000, 1'b0, 1'b0);
    next_cycle(); expect_cyc("lw.c8", 5'b10000, 1'b0, 1'b1);
    next_cycle();
    check("lw.rc", retired_count, 32'd2);

    // div with alu_busy for 10 cycles: P2 lasts 11
    op = 6'h00; irfunc = 6'h1A;
    expect_cyc("div.c1", 5'b00001, 1'b0, 1'b0);
    next_cycle(); expect_cyc("div.c2", 5'b00010, 1'b0, 1'b0);
    next_cycle(); alu_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expect_cyc("div.busy", 5'b00100, 1'b1, 1'b0);
      next_cycle();
    end
    alu_busy = 1'b0;
    expect_cyc("div.p2last", 5'b00100, 1'b0, 1'b0);
    next_cycle(); expect_cyc("div.p4", 5'b10000, 1'b0, 1'b1);
    next_cycle();
    check("div.rc", retired_count, 32'd3);

    // beq ignores alu_busy, retires in P2
    op = 6'h04; irfunc = 6'h00; alu_busy = 1'b1;
    expect_cyc("beq.c1", 5'b00001, 1'b0, 1'b0);
    next_cycle(); expect_cyc("beq.c2", 5'b00010, 1'b0, 1'b0);
    next_cycle(); expect_cyc("beq.c3", 5'b00100, 1'b0, 1'b1);
    next_cycle(); alu_busy = 1'b0;
    expect_cyc("beq.next", 5'b00001, 1'b0, 1'b0);
    check("beq.rc", retired_count, 32'd4);

    // illegal opcode: pulse in P1, back to P0, no retire
    op = 6'h3F;
    expect_cyc("ill.c1", 5'b00001, 1'b0, 1'b0);
    next_cycle(); expect_cyc("ill.c2", 5'b00010, 1'b0, 1'b0);
    check("ill.pulse", 32'(illegal), 32'd1);
    next_cycle(); expect_cyc("ill.next", 5'b00001, 1'b0, 1'b0);
    check("ill.clear", 32'(illegal), 32'd0);
    check("ill.rc", retired_count, 32'd4);

    // sw interrupted by reset in P3
    op = 6'h2B;
    expect_cyc("sw.c1", 5'b00001, 1'b0, 1'b0);
    next_cycle(); expect_cyc("sw.c2", 5'b00010, 1'b0, 1'b0);
    next_cycle(); expect_cyc("sw.c3", 5'b00100, 1'b0, 1'b0);
    next_cycle(); mem_ready = 1'b0;
    expect_cyc("sw.c4", 5'b01000, 1'b1, 1'b0);
    reset = 1'b1;
    expect_cyc("sw.rst", 5'b00001, 1'b0, 1'b0);
    check("sw.rst.cc", cycle_count, 32'd0);
    check("sw.rst.rc", retired_count, 32'd0);
    next_cycle();
    reset = 1'b0; mem_ready = 1'b1; op = 6'h00; irfunc = 6'h20;
    expect_cyc("res.c1", 5'b00001, 1'b0, 1'b0);
    check("res.cc0", cycle_count, 32'd0);
    next_cycle(); expect_cyc("res.c2", 5'b00010, 1'b0, 1'b0);
    check("res.cc1", cycle_count, 32'd1);
    next_cycle(); expect_cyc("res.c3", 5'b00100, 1'b0, 1'b0);
    next_cycle(); expect_cyc("res.c4", 5'b10000, 1'b0, 1'b1);
    next_cycle();
    check("res.rc", retired_count, 32'd1);

    // run falls mid-instruction: instruction completes, then holds at P0
    expect_cyc("rf.c1", 5'b00001, 1'b0, 1'b0);
    next_cycle(); run = 1'b0;
    expect_cyc("rf.c2", 5'b00010, 1'b0, 1'b0);
    next_cycle(); expect_cyc("rf.c3", 5'b00100, 1'b0, 1'b0);
    next_cycle(); expect_cyc("rf.c4", 5'b10000, 1'b0, 1'b1);
    next_cycle(); expect_cyc("rf.hold", 5'b00001, 1'b1, 1'b0);
    check("rf.rc", retired_count, 32'd2);
    next_cycle(); expect_cyc("rf.hold2", 5'b00001, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
